// File: rtl/control_pkg.sv
// Shared encodings and the opcode/funct dispatch table for the microprogrammed
// control unit.
package control_pkg;

  localparam int unsigned ST_W = 7;

  typedef enum logic [2:0] {
    N_ENC      = 3'b000,
    N_FETCH    = 3'b001,
    N_CR       = 3'b010,
    N_INC      = 3'b011,
    N_CR_INC   = 3'b100,
    N_CR_ENC   = 3'b101,
    N_INC_HOLD = 3'b110,
    N_ENC_HOLD = 3'b111
  } n_sel_e;

  typedef enum logic [1:0] {
    S_MOC    = 2'b00,
    S_COND   = 2'b01,
    S_ZERO   = 2'b10,
    S_CONST0 = 2'b11
  } s_sel_e;

  localparam logic [ST_W-1:0] S_FETCH0  = 7'd0;
  localparam logic [ST_W-1:0] S_ILLEGAL = 7'd5;

  typedef struct packed {
    logic            hit;
    logic [ST_W-1:0] state;
  } enc_res_t;

  // funct is only meaningful for R-type (opcode 0)
  function automatic enc_res_t enc_lookup(input logic [5:0] opcode, input logic [5:0] funct);
    enc_res_t res;
    res = '{hit: 1'b1, state: S_ILLEGAL};
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21:   res.state = 7'd6;
          6'h23:   res.state = 7'd7;
          default: res.hit = 1'b0;
        endcase
      end
      6'h09:   res.state = 7'd17;
      6'h23:   res.state = 7'd37;
      6'h2B:   res.state = 7'd34;
      6'h04:   res.state = 7'd31;
      6'h02:   res.state = 7'd44;
      default: res.hit = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instruction_encoder.sv
// Combinational instruction dispatch: maps {opcode, funct} to the microstore
// entry state for that instruction.
module instruction_encoder
  import control_pkg::*;
#(
  parameter int unsigned StateW       = ST_W,
  parameter int unsigned IllegalState = 5
) (
  input  logic [5:0]        opcode_i,
  input  logic [5:0]        funct_i,
  output logic [StateW-1:0] enc_o
);

  enc_res_t res;

  always_comb begin
    res   = enc_lookup(opcode_i, funct_i);
    enc_o = res.hit ? StateW'(res.state) : StateW'(IllegalState);
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-state engine for the microprogrammed control unit, with a watchdog that
// aborts to the illegal state when a hold (MOC wait) runs too long.
module micro_sequencer
  import control_pkg::*;
#(
  parameter int unsigned STATE_W       = 7,
  parameter int unsigned FETCH_STATE   = 0,
  parameter int unsigned ILLEGAL_STATE = 5,
  parameter int unsigned MAX_WAIT      = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         n_sel,
  input  logic               inv,
  input  logic [1:0]         s_sel,
  input  logic [STATE_W-1:0] cr,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               moc,
  input  logic               cond,
  input  logic               zero,
  output logic [STATE_W-1:0] current_state,
  output logic               timeout,
  output logic [3:0]         wait_cnt
);

  localparam logic [STATE_W-1:0] FetchSt   = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] IllegalSt = STATE_W'(ILLEGAL_STATE);
  localparam logic [3:0]         MaxWait   = 4'(MAX_WAIT);

  logic [STATE_W-1:0] state_d, state_q;
  logic               timeout_d, timeout_q;
  logic [3:0]         wait_cnt_d, wait_cnt_q;
  logic [STATE_W-1:0] enc, inc;
  logic               c_raw, c, hold_sel;

  instruction_encoder #(
    .StateW      (STATE_W),
    .IllegalState(ILLEGAL_STATE)
  ) u_encoder (
    .opcode_i(opcode),
    .funct_i (funct),
    .enc_o   (enc)
  );

  always_comb begin
    unique case (s_sel_e'(s_sel))
      S_MOC:    c_raw = moc;
      S_COND:   c_raw = cond;
      S_ZERO:   c_raw = zero;
      S_CONST0: c_raw = 1'b0;
      default:  c_raw = 1'b0;
    endcase
    c = c_raw ^ inv;
  end

  assign inc = state_q + STATE_W'(1);

  always_comb begin
    state_d    = state_q;
    timeout_d  = timeout_q;
    wait_cnt_d = 4'd0;
    hold_sel   = 1'b0;
    unique case (n_sel_e'(n_sel))
      N_ENC:      state_d = enc;
      N_FETCH:    state_d = FetchSt;
      N_CR:       state_d = cr;
      N_INC:      state_d = inc;
      N_CR_INC:   state_d = c ? cr : inc;
      N_CR_ENC:   state_d = c ? cr : enc;
      N_INC_HOLD: if (c) state_d = inc; else hold_sel = 1'b1;
      N_ENC_HOLD: if (c) state_d = enc; else hold_sel = 1'b1;
      default:    state_d = state_q;
    endcase
    // A satisfied condition always wins over an expiring watchdog.
    if (hold_sel) begin
      if (wait_cnt_q == MaxWait) begin
        state_d   = IllegalSt;
        timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FetchSt;
      timeout_q  <= 1'b0;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign current_state = state_q;
  assign timeout       = timeout_q;
  assign wait_cnt      = wait_cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: the driver queues expected outputs per
// edge, a monitor pops and compares them on the following falling edge.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] n_sel;
  logic       inv;
  logic [1:0] s_sel;
  logic [6:0] cr;
  logic [5:0] opcode, funct;
  logic       moc, cond, zero;
  logic [6:0] current_state;
  logic       timeout;
  logic [3:0] wait_cnt;

  micro_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .n_sel        (n_sel),
    .inv          (inv),
    .s_sel        (s_sel),
    .cr           (cr),
    .opcode       (opcode),
    .funct        (funct),
    .moc          (moc),
    .cond         (cond),
    .zero         (zero),
    .current_state(current_state),
    .timeout      (timeout),
    .wait_cnt     (wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] st;
    logic       to;
    logic [3:0] wc;
  } exp_t;

  exp_t q[$];
  event sample_now;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: compares on every falling edge, or immediately for async events.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_now);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (current_state === e.st && timeout === e.to && wait_cnt === e.wc) n_pass++;
        else $display("FAIL %s: got state=%0d timeout=%0b wait_cnt=%0d, want state=%0d timeout=%0b wait_cnt=%0d",
                      e.name, current_state, timeout, wait_cnt, e.st, e.to, e.wc);
      end
    end
  end

  task automatic push(input string nm, input logic [6:0] st, input logic to, input logic [3:0] wc);
    exp_t e;
    e.name = nm;
    e.st   = st;
    e.to   = to;
    e.wc   = wc;
    q.push_back(e);
  endtask

  task automatic tick(input string nm, input logic [6:0] st, input logic to, input logic [3:0] wc);
    @(posedge clk);
    push(nm, st, to, wc);
    @(negedge clk);
  endtask

  task automatic set(input logic [2:0] n, input logic i, input logic [1:0] s, input logic [6:0] c);
    n_sel = n;
    inv   = i;
    s_sel = s;
    cr    = c;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b0;
    set(3'b011, 1'b1, 2'b01, 7'd99);
    opcode = 6'h23; funct = 6'h21; moc = 1'b1; cond = 1'b1; zero = 1'b1;
    #2;
    push("reset_state", 7'd0, 1'b0, 4'd0);
    -> sample_now;
    @(negedge clk);
    reset = 1'b1;
    moc = 1'b0; cond = 1'b0; zero = 1'b0;
    tick("release_inc", 7'd1, 1'b0, 4'd0);

    set(3'b000, 1'b0, 2'b00, 7'd0);
    opcode = 6'h23;                tick("enc_lw", 7'd37, 1'b0, 4'd0);
    opcode = 6'h00; funct = 6'h21; tick("enc_addu", 7'd6, 1'b0, 4'd0);
    funct = 6'h23;                 tick("enc_subu", 7'd7, 1'b0, 4'd0);
    funct = 6'h20;                 tick("enc_bad_funct", 7'd5, 1'b0, 4'd0);
    opcode = 6'h3F;                tick("enc_illegal", 7'd5, 1'b0, 4'd0);
    opcode = 6'h09; funct = 6'h21; tick("enc_addiu", 7'd17, 1'b0, 4'd0);
    opcode = 6'h2B;                tick("enc_sw", 7'd34, 1'b0, 4'd0);
    opcode = 6'h02;                tick("enc_j", 7'd44, 1'b0, 4'd0);
    set(3'b001, 1'b0, 2'b00, 7'd0); tick("fetch", 7'd0, 1'b0, 4'd0);

    opcode = 6'h04;
    set(3'b010, 1'b0, 2'b01, 7'd31); tick("load_31a", 7'd31, 1'b0, 4'd0);
    set(3'b100, 1'b0, 2'b01, 7'd44); cond = 1'b1; tick("br_taken", 7'd44, 1'b0, 4'd0);
    set(3'b010, 1'b0, 2'b01, 7'd31); tick("load_31b", 7'd31, 1'b0, 4'd0);
    set(3'b100, 1'b0, 2'b01, 7'd44); cond = 1'b0; tick("br_not_taken", 7'd32, 1'b0, 4'd0);
    set(3'b010, 1'b0, 2'b01, 7'd31); tick("load_31c", 7'd31, 1'b0, 4'd0);
    set(3'b100, 1'b1, 2'b01, 7'd44); tick("br_inv_taken", 7'd44, 1'b0, 4'd0);
    set(3'b101, 1'b1, 2'b11, 7'd20); tick("cr_enc_const1", 7'd20, 1'b0, 4'd0);
    set(3'b101, 1'b0, 2'b11, 7'd20); tick("cr_enc_const0", 7'd31, 1'b0, 4'd0);

    set(3'b110, 1'b0, 2'b00, 7'd0); moc = 1'b0;
    tick("moc_wait1", 7'd31, 1'b0, 4'd1);
    tick("moc_wait2", 7'd31, 1'b0, 4'd2);
    tick("moc_wait3", 7'd31, 1'b0, 4'd3);
    moc = 1'b1; tick("moc_done", 7'd32, 1'b0, 4'd0);

    set(3'b111, 1'b0, 2'b10, 7'd0); zero = 1'b1; tick("zero_enc", 7'd31, 1'b0, 4'd0);
    zero = 1'b0; tick("zero_hold", 7'd31, 1'b0, 4'd1);
    set(3'b011, 1'b0, 2'b00, 7'd0); tick("hold_clear", 7'd32, 1'b0, 4'd0);

    set(3'b010, 1'b0, 2'b00, 7'd2); tick("load_2a", 7'd2, 1'b0, 4'd0);
    set(3'b110, 1'b0, 2'b00, 7'd0); moc = 1'b0;
    for (int k = 1; k <= 15; k++) tick("wd_count", 7'd2, 1'b0, 4'(k));
    tick("wd_expire", 7'd5, 1'b1, 4'd0);
    set(3'b011, 1'b0, 2'b00, 7'd0); tick("timeout_sticky", 7'd6, 1'b1, 4'd0);
    set(3'b001, 1'b0, 2'b00, 7'd0); tick("timeout_sticky2", 7'd0, 1'b1, 4'd0);

    reset = 1'b0; tick("sync_reset", 7'd0, 1'b0, 4'd0);
    reset = 1'b1;
    set(3'b010, 1'b0, 2'b00, 7'd2); tick("load_2b", 7'd2, 1'b0, 4'd0);
    set(3'b110, 1'b0, 2'b00, 7'd0); moc = 1'b0;
    for (int k = 1; k <= 15; k++) tick("wd_count_b", 7'd2, 1'b0, 4'(k));
    moc = 1'b1; tick("wd_moc_wins", 7'd3, 1'b0, 4'd0);

    set(3'b010, 1'b0, 2'b00, 7'd127); tick("load_127", 7'd127, 1'b0, 4'd0);
    set(3'b011, 1'b0, 2'b00, 7'd0);   tick("wrap", 7'd0, 1'b0, 4'd0);

    set(3'b010, 1'b0, 2'b00, 7'd50); tick("load_50", 7'd50, 1'b0, 4'd0);
    set(3'b110, 1'b0, 2'b00, 7'd0); moc = 1'b0;
    tick("pre_abort1", 7'd50, 1'b0, 4'd1);
    tick("pre_abort2", 7'd50, 1'b0, 4'd2);
    #1 reset = 1'b0;
    #1 push("async_reset", 7'd0, 1'b0, 4'd0);
    -> sample_now;
    #1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d pending, want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
